// File: rtl/dmem_responder.sv
// Single-port data memory responder: one load/store at a time, fixed wait latency,
// byte/half/word access with sign/zero extension and an error response.
module dmem_lane #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = 8,
  parameter int VEC_W       = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    idx,
  input  logic [VEC_W-1:0] wd,
  output logic [VEC_W-1:0] rd
);
  logic [VEC_W-1:0] mem [DEPTH_WORDS];

  // Storage is intentionally never reset.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wd;
  end

  assign rd = mem[idx];
endmodule

module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;
  localparam int AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW        = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dmem_req_t;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  dmem_req_t     cur, lat_req, acc;
  logic          go_resp, acc_err;
  logic [NUM_LANES-1:0]            lane_mask;
  logic [NUM_LANES-1:0][VEC_W-1:0] wd_lanes, rd_lanes;
  logic [VEC_W-1:0]                byte_sel;
  logic [15:0]                     half_sel;
  logic [31:0]                     ld_data, rdata_nxt;

  always_comb begin
    cur.we    = req_we;
    cur.size  = req_size;
    cur.uns   = req_unsigned;
    cur.addr  = req_addr;
    cur.wdata = req_wdata;
  end

  // With zero wait the access uses the live request on the accept edge.
  assign acc     = (state == S_IDLE) ? cur : lat_req;
  assign go_resp = ((state == S_IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                   ((state == S_WAIT) && (cnt == '0));

  assign acc_err = (acc.size == 2'b11) ||
                   ((acc.size == 2'b01) && acc.addr[0]) ||
                   ((acc.size == 2'b10) && (acc.addr[1:0] != 2'b00)) ||
                   ({2'b00, acc.addr[31:2]} >= 32'(DEPTH_WORDS));

  always_comb begin
    lane_mask = '0;
    wd_lanes  = acc.wdata;
    case (acc.size)
      2'b00: begin
        lane_mask[acc.addr[1:0]] = 1'b1;
        wd_lanes = {NUM_LANES{acc.wdata[7:0]}};
      end
      2'b01: begin
        lane_mask = acc.addr[1] ? 4'b1100 : 4'b0011;
        wd_lanes  = {2{acc.wdata[15:0]}};
      end
      default: lane_mask = 4'b1111;
    endcase
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    dmem_lane #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW), .VEC_W(VEC_W)) u_lane (
      .clk (clk),
      .we  (go_resp && acc.we && !acc_err && lane_mask[i]),
      .idx (acc.addr[AW+1:2]),
      .wd  (wd_lanes[i]),
      .rd  (rd_lanes[i])
    );
  end

  assign byte_sel = rd_lanes[acc.addr[1:0]];
  assign half_sel = acc.addr[1] ? {rd_lanes[3], rd_lanes[2]} : {rd_lanes[1], rd_lanes[0]};

  always_comb begin
    case (acc.size)
      2'b00:   ld_data = acc.uns ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   ld_data = acc.uns ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: ld_data = rd_lanes;
    endcase
  end

  assign rdata_nxt = (acc_err || acc.we) ? 32'h0 : ld_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      lat_req   <= '0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          lat_req <= cur;
          if (WAIT_CYCLES > 0) begin
            state <= S_WAIT;
            cnt   <= CW'(WAIT_CYCLES - 1);
          end else begin
            state <= S_RESP;
          end
        end
        S_WAIT: begin
          if (cnt == '0) state <= S_RESP;
          else           cnt   <= cnt - CW'(1);
        end
        S_RESP: if (rsp_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      if (go_resp) begin
        rsp_rdata <= rdata_nxt;
        rsp_err   <= acc_err;
      end
    end
  end

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: WAIT_CYCLES=2 main instance plus a
// zero-wait instance for latency.
module tb_dmem_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        req_valid0, req_ready0, rsp_valid0, rsp_ready0, rsp_err0;
  logic [31:0] rsp_rdata0;

  int checks = 0;
  int failures = 0;
  logic [32:0] exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid0),
    .rsp_ready(rsp_ready0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Pops one expectation per completed response handshake.
  always @(negedge clk) begin
    if (rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) chk("sb_unexpected_rsp", {rsp_err, rsp_rdata}, 33'h0);
      else chk(tag_q.pop_front(), {rsp_err, rsp_rdata}, exp_q.pop_front());
    end
  end

  task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
  endtask

  task automatic wait_rsp_done(input string tag);
    int n = 0;
    while (!(rsp_valid && rsp_ready) && n < 40) begin
      @(negedge clk); n++;
    end
    if (n >= 40) chk({tag, "_timeout"}, 1, 0);
    @(posedge clk); #1;
  endtask

  task automatic send(input string tag, input logic we, input logic [1:0] size,
                      input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic exp_err, input logic [31:0] exp_rd);
    int n = 0;
    @(negedge clk);
    drive(we, size, uns, addr, wdata);
    req_valid = 1'b1;
    exp_q.push_back({exp_err, exp_rd});
    tag_q.push_back(tag);
    while (!req_ready && n < 40) begin
      @(negedge clk); n++;
    end
    if (n >= 40) chk({tag, "_accept_timeout"}, 1, 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_rsp_done(tag);
  endtask

  task automatic lat0(input string tag, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rd);
    int lat;
    @(negedge clk);
    drive(we, 2'b10, 1'b0, addr, wdata);
    req_valid0 = 1'b1;
    @(posedge clk); #1;
    req_valid0 = 1'b0;
    lat = 1;
    while (!rsp_valid0 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    chk({tag, "_lat"}, lat, 1);
    chk({tag, "_data"}, {rsp_err0, rsp_rdata0}, {1'b0, exp_rd});
    @(posedge clk); #1;
  endtask

  initial begin
    int lat, n;
    rst = 1'b0; rsp_ready = 1'b1; rsp_ready0 = 1'b1;
    req_valid = 1'b0; req_valid0 = 1'b0;
    drive(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", {rsp_err, rsp_rdata}, 33'h0);
    chk("rst_req_ready0", req_ready0, 1);
    rst = 1'b1;

    // Reset in the middle of WAIT must drop the store.
    send("sw_10", 1, 2'b10, 0, 32'h10, 32'h11111111, 0, 32'h0);
    @(negedge clk);
    drive(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0; #1;
    chk("rst_mid_req_ready", req_ready, 1);
    chk("rst_mid_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    rst = 1'b1;
    send("lw_10_after_rst", 0, 2'b10, 0, 32'h10, 32'h0, 0, 32'h11111111);

    send("sw_00", 1, 2'b10, 0, 32'h00, 32'h55AA55AA, 0, 32'h0);
    send("sw_20", 1, 2'b10, 0, 32'h20, 32'h80FF7F01, 0, 32'h0);
    send("lb_21",  0, 2'b00, 0, 32'h21, 32'h0, 0, 32'h0000007F);
    send("lb_22",  0, 2'b00, 0, 32'h22, 32'h0, 0, 32'hFFFFFFFF);
    send("lbu_22", 0, 2'b00, 1, 32'h22, 32'h0, 0, 32'h000000FF);
    send("lh_22",  0, 2'b01, 0, 32'h22, 32'h0, 0, 32'hFFFF80FF);
    send("lhu_22", 0, 2'b01, 1, 32'h22, 32'h0, 0, 32'h000080FF);
    send("lw_20",  0, 2'b10, 1, 32'h20, 32'h0, 0, 32'h80FF7F01);

    send("sb_23", 1, 2'b00, 0, 32'h23, 32'h123456AB, 0, 32'h0);
    send("lw_20_sb", 0, 2'b10, 0, 32'h20, 32'h0, 0, 32'hABFF7F01);
    send("sh_20", 1, 2'b01, 0, 32'h20, 32'h9999CDEF, 0, 32'h0);
    send("lw_20_sh", 0, 2'b10, 0, 32'h20, 32'h0, 0, 32'hABFFCDEF);
    send("lb_20",    0, 2'b00, 0, 32'h20, 32'h0, 0, 32'hFFFFFFEF);
    send("sh_22", 1, 2'b01, 0, 32'h22, 32'h00007E12, 0, 32'h0);
    send("lw_20_sh2", 0, 2'b10, 0, 32'h20, 32'h0, 0, 32'h7E12CDEF);

    send("err_lw_22",  0, 2'b10, 0, 32'h22,  32'h0, 1, 32'h0);
    send("err_lh_01",  0, 2'b01, 0, 32'h01,  32'h0, 1, 32'h0);
    send("err_sz3_ld", 0, 2'b11, 0, 32'h20,  32'h0, 1, 32'h0);
    send("err_lw_400", 0, 2'b10, 0, 32'h400, 32'h0, 1, 32'h0);
    send("err_sw_22",  1, 2'b10, 0, 32'h22,  32'hFFFFFFFF, 1, 32'h0);
    send("err_sh_21",  1, 2'b01, 0, 32'h21,  32'hFFFFFFFF, 1, 32'h0);
    send("err_sz3_st", 1, 2'b11, 0, 32'h20,  32'hFFFFFFFF, 1, 32'h0);
    send("err_sw_400", 1, 2'b10, 0, 32'h400, 32'hFFFFFFFF, 1, 32'h0);
    send("lw_20_unch", 0, 2'b10, 0, 32'h20,  32'h0, 0, 32'h7E12CDEF);
    send("lw_00_unch", 0, 2'b10, 0, 32'h00,  32'h0, 0, 32'h55AA55AA);
    send("sw_3fc", 1, 2'b10, 0, 32'h3FC, 32'hCAFEF00D, 0, 32'h0);
    send("lw_3fc", 0, 2'b10, 0, 32'h3FC, 32'h0, 0, 32'hCAFEF00D);

    // Accept-to-valid latency, WAIT_CYCLES=2.
    @(negedge clk);
    drive(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    req_valid = 1'b1;
    exp_q.push_back({1'b0, 32'h7E12CDEF});
    tag_q.push_back("lat_w2_data");
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    chk("lat_w2", lat, 3);
    wait_rsp_done("lat_w2");

    lat0("w0_sw", 1, 32'h40, 32'h01020304, 32'h0);
    lat0("w0_lw", 0, 32'h40, 32'h0, 32'h01020304);

    // Backpressure with a second request held on the input.
    rsp_ready = 1'b0;
    @(negedge clk);
    drive(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    req_valid = 1'b1;
    exp_q.push_back({1'b0, 32'h7E12CDEF});
    tag_q.push_back("bp_first");
    @(posedge clk); #1;
    drive(1'b0, 2'b00, 1'b1, 32'h23, 32'h0);
    exp_q.push_back({1'b0, 32'h0000007E});
    tag_q.push_back("bp_second");
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk); n++;
    end
    if (n >= 20) chk("bp_valid_timeout", 1, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", rsp_valid, 1);
      chk("bp_hold_data", {rsp_err, rsp_rdata}, {1'b0, 32'h7E12CDEF});
      chk("bp_hold_req_ready", req_ready, 0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_hs_req_ready", req_ready, 0);
    @(negedge clk);
    chk("bp_after_req_ready", req_ready, 1);
    chk("bp_after_rsp_valid", rsp_valid, 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_rsp_done("bp_second");

    repeat (3) @(negedge clk);
    chk("sb_drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
